sha256_round_engine: RTL and testbench
======================================

Name: sha256_round_engine

Overview:
Reader side of the round_constant ROM interface: drives the ROM's enable/address, consumes the returned round constant K_t together with message word W_t, and runs the 64-round SHA-256 compression on one 512-bit block. Sits between the message scheduler/round_constant ROM and the top-level hash controller. Loads the chaining value on start and returns the updated 256-bit hash with a one-cycle done pulse.

Parameters:
ADDR_WTH, 6, ROM address width; the round count is 2**ADDR_WTH = 64.
WRD_SIZE, 32, word width of K_t, W_t and working variables a..h.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  begin compression; sampled only in IDLE.
i_hash_init  input  8*WRD_SIZE  chaining value H0..H7, H0 in MSBs; sampled with start.
o_rc_enable  output  1  ROM read enable, to round_constant.enable.
o_rc_add  output  ADDR_WTH  ROM address, to round_constant.add.
i_round_constant  input  WRD_SIZE  K_t from round_constant.o_round_constant.
o_w_next  output  1  request next W_t from the scheduler, same timing as o_rc_enable.
i_w  input  WRD_SIZE  W_t, valid the cycle after o_w_next.
o_busy  output  1  high from the cycle after start is accepted until o_done.
o_done  output  1  one-cycle pulse; o_hash valid from this cycle.
o_hash  output  8*WRD_SIZE  result H0'..H7', held until the next accepted start.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; round counter, a..h, H regs and o_hash = 0; o_rc_enable, o_w_next, o_busy, o_done = 0; o_rc_add = 0. Reset mid-operation aborts immediately with no partial hash; the next start works normally.
- ROM contract (fixed): synchronous read; K_t appears on i_round_constant the cycle after add=t is presented with enable=1. The scheduler supplies i_w with the same one-cycle latency.
- FSM states: IDLE -> PRIME -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE, cycle c: start=1 latches i_hash_init into H0..H7 and into a..h; the FSM goes to PRIME.
- PRIME (c+1): o_rc_enable=1, o_w_next=1, o_rc_add=0; t=0; o_busy=1.
- ROUND (c+2..c+65):
  - Each cycle applies one SHA-256 round with K_t and W_t:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t.
    - T2 = Σ0(a) + Maj(a,b,c).
    - Shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
    - All additions are mod 2^32.
  - While t<63: o_rc_enable=1, o_w_next=1, o_rc_add=t+1, then t increments.
  - At t=63: o_rc_enable=0, o_w_next=0, o_rc_add holds 63; no wrap to 0. The FSM goes to FINAL.
- FINAL (c+66): Hi += working var (mod 2^32); o_hash loads the sums.
- DONE (c+67): o_done=1 for one cycle, o_busy=0; the FSM returns to IDLE. Start-to-done latency is exactly 67 cycles.
- start while o_busy=1 or in DONE is ignored, with no effect on the computation in progress. start in the IDLE cycle immediately after DONE is accepted (back-to-back).
- o_rc_enable is never high outside PRIME and ROUND(t<63). Exactly 64 reads per block, addresses 0..63 in order.
- o_hash is stable between o_done pulses; it is not cleared by a new start until FINAL of the new block.

Decomposition:
- Shared package sha_pkg:
  - Word width constants.
  - FSM state encoding.
  - SHA-256 IV constants H0..H7 (for benches and top level).
  - Functions Σ0, Σ1, Ch, Maj.
- One natural sub-module: sha256_round_fn. Combinational single round: takes a..h, K_t and W_t; outputs the next a..h. It is instantiated once in the ROUND datapath.

Test Plan:
- Message "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, W16..63 from the bench scheduler model), i_hash_init=IV, real round_constant ROM:
  - o_done exactly 67 cycles after start.
  - o_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (W0=0x80000000, rest 0 before the schedule), IV:
  - o_hash = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Address monitor during any block:
  - o_rc_enable high for exactly 64 consecutive cycles starting c+1.
  - o_rc_add = 0,1,...,63 in order, with no repeat or wrap.
  - o_w_next is identical to o_rc_enable.
- start pulsed at c+10 and c+40 during the "abc" run:
  - Ignored; single o_done at c+67 with the correct "abc" digest.
- reset_n low for 1 cycle during ROUND t=30:
  - All outputs 0 immediately.
  - A fresh start then yields the empty-message digest after 67 cycles.
- Back-to-back: start on the IDLE cycle after DONE with i_hash_init = "abc" digest.
  - Accepted; done 67 cycles later.
  - o_hash matches the bench's two-block chained reference.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word/state types, FSM encoding, IV and round helper functions.
package sha_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;

    typedef logic [WORD_W-1:0] word_t;
    // Element [7] is a / H0 so the packed vector lines up with H0-in-MSBs buses.
    typedef word_t [NUM_WORDS-1:0] hstate_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } fsm_t;

    localparam hstate_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_engine_round_fn.sv
// One combinational SHA-256 round: working variables a..h plus K_t/W_t in, next a..h out.
module sha256_round_fn
    import sha_pkg::*;
(
    input  hstate_t cur,
    input  word_t   k,
    input  word_t   w,
    output hstate_t nxt
);

    word_t t1;
    word_t t2;

    // Index map: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=h
    always_comb begin
        t1  = cur[0] + big_sigma1(cur[3]) + ch(cur[3], cur[2], cur[1]) + k + w;
        t2  = big_sigma0(cur[7]) + maj(cur[7], cur[6], cur[5]);
        nxt = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};
    end

endmodule

// File: rtl/sha256_round_engine.sv
// 64-round SHA-256 compression of one block, fetching K_t/W_t through a one-cycle-latency read port.
module sha256_round_engine
    import sha_pkg::*;
#(
    parameter int ADDR_WTH = 6,
    parameter int WRD_SIZE = WORD_W
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [8*WRD_SIZE-1:0]   i_hash_init,
    output logic                    o_rc_enable,
    output logic [ADDR_WTH-1:0]     o_rc_add,
    input  logic [WRD_SIZE-1:0]     i_round_constant,
    output logic                    o_w_next,
    input  logic [WRD_SIZE-1:0]     i_w,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [8*WRD_SIZE-1:0]   o_hash
);

    localparam logic [ADDR_WTH-1:0] LAST_ROUND = '1;
    localparam logic [ADDR_WTH-1:0] ADDR_ONE   = {{(ADDR_WTH-1){1'b0}}, 1'b1};

    fsm_t                state_reg;
    fsm_t                state_next;
    logic [ADDR_WTH-1:0] round_reg;
    logic [ADDR_WTH-1:0] add_reg;
    hstate_t             work_reg;
    hstate_t             h_reg;
    hstate_t             hash_reg;
    hstate_t             work_next_rnd;
    hstate_t             sum;

    sha256_round_fn u_round_fn (
        .cur (work_reg),
        .k   (i_round_constant),
        .w   (i_w),
        .nxt (work_next_rnd)
    );

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_sum
        assign sum[gi] = h_reg[gi] + work_reg[gi];
    end

    always_comb begin
        state_next  = state_reg;
        o_rc_enable = 1'b0;
        o_w_next    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_PRIME;
            end
            ST_PRIME: begin
                state_next  = ST_ROUND;
                o_rc_enable = 1'b1;
                o_w_next    = 1'b1;
                o_busy      = 1'b1;
            end
            ST_ROUND: begin
                o_busy = 1'b1;
                // The last round consumes K_63 already in flight; no further read is issued.
                if (round_reg == LAST_ROUND) begin
                    state_next = ST_FINAL;
                end else begin
                    o_rc_enable = 1'b1;
                    o_w_next    = 1'b1;
                end
            end
            ST_FINAL: begin
                state_next = ST_DONE;
                o_busy     = 1'b1;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                o_done     = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_rc_add = add_reg;
    assign o_hash   = hash_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            round_reg <= '0;
            add_reg   <= '0;
            work_reg  <= '0;
            h_reg     <= '0;
            hash_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        h_reg     <= i_hash_init;
                        work_reg  <= i_hash_init;
                        round_reg <= '0;
                        add_reg   <= '0;
                    end
                end
                ST_PRIME: add_reg <= add_reg + ADDR_ONE;
                ST_ROUND: begin
                    work_reg <= work_next_rnd;
                    if (round_reg != LAST_ROUND) begin
                        round_reg <= round_reg + ADDR_ONE;
                        // Address saturates at the last entry instead of wrapping.
                        if (add_reg != LAST_ROUND) add_reg <= add_reg + ADDR_ONE;
                    end
                end
                ST_FINAL: begin
                    h_reg    <= sum;
                    hash_reg <= sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine with a K ROM, a W scheduler model and a digest scoreboard.
module tb_sha256_round_engine;
    import sha_pkg::*;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] ABC_BLOCK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLOCK = {32'h80000000, 480'h0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] hash;
        int           start_cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [255:0] i_hash_init;
    logic         o_rc_enable;
    logic [5:0]   o_rc_add;
    logic [31:0]  i_round_constant;
    logic         o_w_next;
    logic [31:0]  i_w;
    logic         o_busy;
    logic         o_done;
    logic [255:0] o_hash;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_start_cyc = 0;
    int           en_run = 0;
    int           exp_addr = 0;
    exp_t         sb_q[$];
    logic [31:0]  w_sched [64];
    logic [255:0] chained;

    sha256_round_engine #(.ADDR_WTH(6), .WRD_SIZE(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .i_hash_init      (i_hash_init),
        .o_rc_enable      (o_rc_enable),
        .o_rc_add         (o_rc_add),
        .i_round_constant (i_round_constant),
        .o_w_next         (o_w_next),
        .i_w              (i_w),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_hash           (o_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read K ROM and message scheduler, both one cycle behind the request.
    always @(posedge clk) begin
        if (o_rc_enable) i_round_constant <= K_TAB[o_rc_add];
        if (o_w_next)    i_w <= w_sched[o_rc_add];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic load_block(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) w_sched[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w_sched[t] = (ror(w_sched[t-2], 17) ^ ror(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                       + w_sched[t-7]
                       + (ror(w_sched[t-15], 7) ^ ror(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                       + w_sched[t-16];
    endtask

    function automatic logic [255:0] model_compress(input logic [255:0] hin);
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w_sched[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // Output monitor: address sequence, read-window shape and scoreboard pops on o_done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            en_run   = 0;
            exp_addr = 0;
        end else begin
            if (o_rc_enable || o_w_next) check("w_next_eq_enable", o_w_next, o_rc_enable);
            if (o_rc_enable) begin
                if (en_run == 0) check("enable_first_cycle", cyc, last_start_cyc + 1);
                check("rc_add_seq", o_rc_add, exp_addr);
                check("busy_while_reading", o_busy, 1);
                en_run++;
                exp_addr++;
            end else if (en_run != 0) begin
                check("enable_run_len", en_run, 64);
                check("rc_add_hold_63", o_rc_add, 63);
                en_run   = 0;
                exp_addr = 0;
            end
            if (o_done) begin
                check("done_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("digest", o_hash, e.hash);
                    check("latency", cyc - e.start_cyc, 67);
                    check("busy_low_at_done", o_busy, 0);
                    $display("done: cycle %0d hash %h", cyc, o_hash);
                end
            end
        end
    end

    task automatic start_block(input logic [255:0] hin, input logic [255:0] expv);
        exp_t e;
        i_hash_init    = hin;
        start          = 1'b1;
        last_start_cyc = cyc;
        e.hash         = expv;
        e.start_cyc    = cyc;
        sb_q.push_back(e);
        $display("start: cycle %0d init %h", cyc, hin);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_a, input int pulse_b,
                             input logic hold_chk, input logic [255:0] hold_val);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(posedge clk); #2;
            start = ((cyc - last_start_cyc) == pulse_a) || ((cyc - last_start_cyc) == pulse_b);
            if (hold_chk && (cyc - last_start_cyc) == 30) check("hash_held", o_hash, hold_val);
            if (o_done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_rc_enable"}, o_rc_enable, 0);
        check({phase, "_w_next"},    o_w_next,    0);
        check({phase, "_busy"},      o_busy,      0);
        check({phase, "_done"},      o_done,      0);
        check({phase, "_rc_add"},    o_rc_add,    0);
        check({phase, "_hash"},      o_hash,      0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        i_hash_init = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Reference model sanity against published digests.
        load_block(EMPTY_BLOCK);
        check("model_empty", model_compress(SHA256_IV), EMPTY_DIGEST);
        load_block(ABC_BLOCK);
        check("model_abc", model_compress(SHA256_IV), ABC_DIGEST);

        // "abc" with ignored starts at c+10 and c+40.
        start_block(SHA256_IV, ABC_DIGEST);
        wait_done(10, 40, 1'b0, '0);

        // Back-to-back chained block on the IDLE cycle right after DONE.
        @(posedge clk); #2;
        load_block(EMPTY_BLOCK);
        chained = model_compress(ABC_DIGEST);
        start_block(ABC_DIGEST, chained);
        wait_done(-1, -1, 1'b1, ABC_DIGEST);

        // Empty message from the IV.
        @(posedge clk); #2;
        start_block(SHA256_IV, EMPTY_DIGEST);
        wait_done(-1, -1, 1'b1, chained);

        // Abort "abc" at round 30 with a one-cycle reset.
        @(posedge clk); #2;
        load_block(ABC_BLOCK);
        start_block(SHA256_IV, ABC_DIGEST);
        for (int n = 0; n < 100 && (cyc - last_start_cyc) < 32; n++) begin
            @(posedge clk); #2;
        end
        check("busy_before_abort", o_busy, 1);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check_all_zero("abort");
        $display("abort: cycle %0d", cyc);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        load_block(EMPTY_BLOCK);
        start_block(SHA256_IV, EMPTY_DIGEST);
        wait_done(-1, -1, 1'b0, '0);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
